// File: rtl/caxi4interconnect_slv_rd_arb.sv
// rtl/caxi4interconnect_slv_rd_arb.sv - slave-port read-address round-robin arbiter with in-order response router
module caxi4interconnect_slv_rd_arb #(
    parameter int NUM_REQ          = 4,
    parameter int ID_WIDTH         = 1,
    parameter int ORDER_DEPTH_LOG2 = 3,
    localparam int GW              = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   REQ_AID,
    input  logic [NUM_REQ-1:0]            REQ_AVALID,
    output logic [NUM_REQ-1:0]            REQ_AREADY,
    output logic [GW-1:0]                 GRANT_IDX,
    output logic [ID_WIDTH-1:0]           SLAVE_AID,
    output logic                          SLAVE_AVALID,
    input  logic                          SLAVE_AREADY,
    input  logic                          SLAVE_RVALID,
    input  logic                          SLAVE_RLAST,
    output logic                          SLAVE_RREADY,
    output logic [NUM_REQ-1:0]            REQ_RVALID,
    input  logic [NUM_REQ-1:0]            REQ_RREADY,
    output logic [ID_WIDTH-1:0]           REQ_RID,
    output logic [ORDER_DEPTH_LOG2:0]     OUTSTANDING,
    output logic                          PROT_ERR
);

    localparam int DEPTH = 1 << ORDER_DEPTH_LOG2;
    localparam logic [ORDER_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {ORDER_DEPTH_LOG2{1'b0}}};

    typedef enum logic {IDLE, ISSUE} stateT;

    stateT                       state;
    logic [GW-1:0]               lastIdx;
    logic [GW-1:0]               winner;
    logic                        anyReq;
    logic                        foundHi;
    logic                        foundLo;
    logic [GW-1:0]               winHi;
    logic [GW-1:0]               winLo;
    logic [ID_WIDTH-1:0]         grantAid;
    logic [GW-1:0]               fifoIdx [DEPTH];
    logic [ID_WIDTH-1:0]         fifoId  [DEPTH];
    logic [ORDER_DEPTH_LOG2-1:0] wrPtr;
    logic [ORDER_DEPTH_LOG2-1:0] rdPtr;
    logic [GW-1:0]               headIdx;
    logic                        empty;
    logic                        full;
    logic                        push;
    logic                        pop;

    assign empty     = (OUTSTANDING == '0);
    assign full      = (OUTSTANDING == FULL_COUNT);
    assign anyReq    = |REQ_AVALID;
    assign headIdx   = fifoIdx[rdPtr];
    assign SLAVE_AID = '0;
    assign push      = (state == ISSUE) && SLAVE_AREADY;
    assign pop       = SLAVE_RVALID && SLAVE_RREADY && SLAVE_RLAST;
    assign REQ_RID   = empty ? '0 : fifoId[rdPtr];

    // Round robin: first requester above lastIdx wins, otherwise wrap to the lowest one.
    always_comb begin
        foundHi = 1'b0;
        foundLo = 1'b0;
        winHi   = '0;
        winLo   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (REQ_AVALID[i] && !foundHi && (GW'(i) > lastIdx)) begin
                foundHi = 1'b1;
                winHi   = GW'(i);
            end
            if (REQ_AVALID[i] && !foundLo) begin
                foundLo = 1'b1;
                winLo   = GW'(i);
            end
        end
        winner = foundHi ? winHi : winLo;
    end

    always_comb begin
        grantAid     = '0;
        REQ_AREADY   = '0;
        REQ_RVALID   = '0;
        SLAVE_RREADY = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == GRANT_IDX) begin
                grantAid      = REQ_AID[i*ID_WIDTH +: ID_WIDTH];
                REQ_AREADY[i] = (state == ISSUE) && SLAVE_AREADY;
            end
            if (!empty && (GW'(i) == headIdx)) begin
                REQ_RVALID[i] = SLAVE_RVALID;
                SLAVE_RREADY  = REQ_RREADY[i];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= IDLE;
            lastIdx      <= GW'(NUM_REQ - 1);
            GRANT_IDX    <= '0;
            SLAVE_AVALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq && !full) begin
                        GRANT_IDX    <= winner;
                        SLAVE_AVALID <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Grant stays locked until the slave accepts, even if AVALID drops.
                    if (SLAVE_AREADY) begin
                        lastIdx      <= GRANT_IDX;
                        SLAVE_AVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            fifoIdx[wrPtr] <= GRANT_IDX;
            fifoId[wrPtr]  <= grantAid;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            OUTSTANDING <= '0;
            PROT_ERR    <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   OUTSTANDING <= OUTSTANDING + 1'b1;
                2'b01:   OUTSTANDING <= OUTSTANDING - 1'b1;
                default: OUTSTANDING <= OUTSTANDING;
            endcase
            if (SLAVE_RVALID && empty) PROT_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_caxi4interconnect_slv_rd_arb.sv
// tb/tb_caxi4interconnect_slv_rd_arb.sv - directed self-checking bench for caxi4interconnect_slv_rd_arb
module tb_caxi4interconnect_slv_rd_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_WIDTH = 3;
    localparam int ODL2 = 3;
    localparam int GW = 2;

    logic                        ACLK;
    logic                        ARESETN;
    logic [NUM_REQ*ID_WIDTH-1:0] REQ_AID;
    logic [NUM_REQ-1:0]          REQ_AVALID;
    logic [NUM_REQ-1:0]          REQ_AREADY;
    logic [GW-1:0]               GRANT_IDX;
    logic [ID_WIDTH-1:0]         SLAVE_AID;
    logic                        SLAVE_AVALID;
    logic                        SLAVE_AREADY;
    logic                        SLAVE_RVALID;
    logic                        SLAVE_RLAST;
    logic                        SLAVE_RREADY;
    logic [NUM_REQ-1:0]          REQ_RVALID;
    logic [NUM_REQ-1:0]          REQ_RREADY;
    logic [ID_WIDTH-1:0]         REQ_RID;
    logic [ODL2:0]               OUTSTANDING;
    logic                        PROT_ERR;

    int checks = 0;
    int errors = 0;

    caxi4interconnect_slv_rd_arb #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .ORDER_DEPTH_LOG2(ODL2)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .REQ_AID(REQ_AID), .REQ_AVALID(REQ_AVALID),
        .REQ_AREADY(REQ_AREADY), .GRANT_IDX(GRANT_IDX), .SLAVE_AID(SLAVE_AID),
        .SLAVE_AVALID(SLAVE_AVALID), .SLAVE_AREADY(SLAVE_AREADY), .SLAVE_RVALID(SLAVE_RVALID),
        .SLAVE_RLAST(SLAVE_RLAST), .SLAVE_RREADY(SLAVE_RREADY), .REQ_RVALID(REQ_RVALID),
        .REQ_RREADY(REQ_RREADY), .REQ_RID(REQ_RID), .OUTSTANDING(OUTSTANDING), .PROT_ERR(PROT_ERR)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        ARESETN = 1'b0;
        REQ_AID = {3'd4, 3'd3, 3'd2, 3'd1};
        REQ_AVALID = '0;
        SLAVE_AREADY = 1'b0;
        SLAVE_RVALID = 1'b0;
        SLAVE_RLAST = 1'b0;
        REQ_RREADY = '0;
        step();
        step();
        check("rst_grant", GRANT_IDX, 0);
        check("rst_savalid", SLAVE_AVALID, 0);
        check("rst_outst", OUTSTANDING, 0);
        check("rst_proterr", PROT_ERR, 0);
        check("rst_aready", REQ_AREADY, 0);
        check("rst_rready", SLAVE_RREADY, 0);
        check("rst_rvalid", REQ_RVALID, 0);
        check("rst_rid", REQ_RID, 0);
        check("rst_said", SLAVE_AID, 0);
        ARESETN = 1'b1;

        // Round robin, no read data returned
        REQ_AVALID = 4'hF;
        SLAVE_AREADY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_avalid", SLAVE_AVALID, 1);
            check("rr_grant", GRANT_IDX, k % 4);
            check("rr_aready", REQ_AREADY, 1 << (k % 4));
            step();
            check("rr_idle", SLAVE_AVALID, 0);
            check("rr_outst", OUTSTANDING, k + 1);
        end
        step();
        step();
        step();
        check("full_nogrant", SLAVE_AVALID, 0);
        check("full_outst", OUTSTANDING, 8);
        check("full_rvalid", REQ_RVALID, 0);
        check("full_rid", REQ_RID, 1);

        // Full FIFO: RLAST pop while a request is pending
        SLAVE_RVALID = 1'b1;
        SLAVE_RLAST = 1'b1;
        REQ_RREADY = 4'hF;
        settle();
        check("fs_rvalid", REQ_RVALID, 4'b0001);
        check("fs_rready", SLAVE_RREADY, 1);
        step();
        check("fs_outst7", OUTSTANDING, 7);
        check("fs_nogrant", SLAVE_AVALID, 0);
        SLAVE_RVALID = 1'b0;
        settle();
        check("fs_rid2", REQ_RID, 2);
        step();
        check("fs_issue", SLAVE_AVALID, 1);
        check("fs_grant", GRANT_IDX, 0);
        step();
        check("fs_outst8", OUTSTANDING, 8);
        REQ_AVALID = '0;

        // Drain through the wrapped pointer: owners 1,2,3,0,1,2,3,0
        SLAVE_RVALID = 1'b1;
        SLAVE_RLAST = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("wrap_rvalid", REQ_RVALID, 1 << ((k + 1) % 4));
            check("wrap_rid", REQ_RID, ((k + 1) % 4) + 1);
            step();
        end
        SLAVE_RVALID = 1'b0;
        settle();
        check("wrap_outst", OUTSTANDING, 0);
        check("wrap_proterr", PROT_ERR, 0);

        // Grant lock
        REQ_AVALID = 4'b0100;
        SLAVE_AREADY = 1'b0;
        step();
        check("lock_grant2", GRANT_IDX, 2);
        REQ_AVALID = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            step();
            check("lock_hold", GRANT_IDX, 2);
            check("lock_avalid", SLAVE_AVALID, 1);
            check("lock_aready0", REQ_AREADY, 0);
        end
        SLAVE_AREADY = 1'b1;
        settle();
        check("lock_aready2", REQ_AREADY, 4'b0100);
        step();
        check("lock_outst1", OUTSTANDING, 1);
        REQ_AVALID = 4'b0001;
        step();
        check("lock_next0", GRANT_IDX, 0);
        check("lock_aready_n", REQ_AREADY, 4'b0001);
        REQ_AVALID = '0;
        step();
        check("lock_outst2", OUTSTANDING, 2);
        SLAVE_RVALID = 1'b1;
        SLAVE_RLAST = 1'b1;
        settle();
        check("lock_rv2", REQ_RVALID, 4'b0100);
        check("lock_rid2", REQ_RID, 3);
        step();
        check("lock_rv0", REQ_RVALID, 4'b0001);
        check("lock_rid0", REQ_RID, 1);
        step();
        SLAVE_RVALID = 1'b0;
        settle();
        check("lock_drained", OUTSTANDING, 0);

        // ID restore with backpressure
        REQ_AID = {3'd2, 3'd0, 3'd5, 3'd0};
        REQ_AVALID = 4'b0010;
        step();
        check("id_grant1", GRANT_IDX, 1);
        step();
        REQ_AVALID = 4'b1000;
        step();
        check("id_grant3", GRANT_IDX, 3);
        step();
        REQ_AVALID = '0;
        check("id_outst2", OUTSTANDING, 2);
        check("id_said", SLAVE_AID, 0);
        SLAVE_RVALID = 1'b1;
        SLAVE_RLAST = 1'b0;
        settle();
        check("bp_rv_b0", REQ_RVALID, 4'b0010);
        check("bp_rid_b0", REQ_RID, 5);
        check("bp_rready_b0", SLAVE_RREADY, 1);
        step();
        check("bp_nonlast", OUTSTANDING, 2);
        REQ_RREADY = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp_rready0", SLAVE_RREADY, 0);
            check("bp_rv_hold", REQ_RVALID, 4'b0010);
            step();
            check("bp_nopop", OUTSTANDING, 2);
        end
        REQ_RREADY = 4'hF;
        for (int b = 1; b < 4; b++) begin
            SLAVE_RLAST = (b == 3);
            settle();
            check("id_rv1", REQ_RVALID, 4'b0010);
            check("id_rid1", REQ_RID, 5);
            step();
        end
        check("id_outst1", OUTSTANDING, 1);
        for (int b = 0; b < 4; b++) begin
            SLAVE_RLAST = (b == 3);
            settle();
            check("id_rv3", REQ_RVALID, 4'b1000);
            check("id_rid3", REQ_RID, 2);
            check("id_said_r", SLAVE_AID, 0);
            step();
        end
        SLAVE_RVALID = 1'b0;
        SLAVE_RLAST = 1'b0;
        settle();
        check("id_outst0", OUTSTANDING, 0);

        // Protocol error on empty FIFO
        SLAVE_RVALID = 1'b1;
        settle();
        check("pe_rready", SLAVE_RREADY, 0);
        check("pe_rvalid", REQ_RVALID, 0);
        step();
        check("pe_set", PROT_ERR, 1);
        SLAVE_RVALID = 1'b0;
        step();
        check("pe_sticky", PROT_ERR, 1);

        // Asynchronous reset mid-burst
        REQ_AVALID = 4'b0100;
        step();
        check("ar_grant2", GRANT_IDX, 2);
        step();
        REQ_AVALID = '0;
        SLAVE_RVALID = 1'b1;
        step();
        check("ar_outst1", OUTSTANDING, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("ar_outst", OUTSTANDING, 0);
        check("ar_proterr", PROT_ERR, 0);
        check("ar_grant", GRANT_IDX, 0);
        check("ar_savalid", SLAVE_AVALID, 0);
        check("ar_rready", SLAVE_RREADY, 0);
        check("ar_rvalid", REQ_RVALID, 0);
        check("ar_aready", REQ_AREADY, 0);
        check("ar_rid", REQ_RID, 0);
        SLAVE_RVALID = 1'b0;
        step();
        ARESETN = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/caxi4interconnect_slv_rd_arb.md
# caxi4interconnect_slv_rd_arb

Read-address arbiter and in-order response router for one slave port of the AXI4 interconnect. It grants the shared read-address channel to NUM_REQ requesters in round-robin order and records each issued grant, with its original ID, in an order FIFO. It then steers the in-order read-data stream back to the owning requester and restores that requester's ID. It sits between the per-master read crossbar paths and a slave that returns read data in issue order with no interleaving.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, valid 2-8; GW = max(1, clog2(NUM_REQ)).
- ID_WIDTH, 1: ID width, valid 1-8.
- ORDER_DEPTH_LOG2, 3: order FIFO holds 2**ORDER_DEPTH_LOG2 outstanding reads.

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- REQ_AID  in  NUM_REQ*ID_WIDTH  per-requester read ID; requester r uses slice r.
- REQ_AVALID  in  NUM_REQ  per-requester address valid.
- REQ_AREADY  out  NUM_REQ  per-requester address ready.
- GRANT_IDX  out  GW  current grant; selects the external address-payload mux.
- SLAVE_AID  out  ID_WIDTH  constant 0 to the slave.
- SLAVE_AVALID  out  1  address valid to the slave.
- SLAVE_AREADY  in  1  address ready from the slave.
- SLAVE_RVALID  in  1  read-data valid from the slave.
- SLAVE_RLAST  in  1  last beat of a burst.
- SLAVE_RREADY  out  1  read-data ready to the slave.
- REQ_RVALID  out  NUM_REQ  per-requester read valid, one-hot or zero.
- REQ_RREADY  in  NUM_REQ  per-requester read ready.
- REQ_RID  out  ID_WIDTH  restored ID of the FIFO-head transaction.
- OUTSTANDING  out  ORDER_DEPTH_LOG2+1  current FIFO occupancy.
- PROT_ERR  out  1  sticky flag: SLAVE_RVALID seen while nothing is outstanding.

## Operation
- Arbiter FSM has two states: IDLE and ISSUE.
- IDLE:
  - A grant is allowed when any REQ_AVALID is set and OUTSTANDING < 2**ORDER_DEPTH_LOG2.
  - The winner is the first set REQ_AVALID bit searched upward from (last+1) mod NUM_REQ.
  - On a grant, register the winner into GRANT_IDX and move to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - SLAVE_AVALID = 1.
  - REQ_AREADY[GRANT_IDX] = SLAVE_AREADY (combinational); all other REQ_AREADY bits are 0.
  - On SLAVE_AREADY, push {GRANT_IDX, REQ_AID[GRANT_IDX]} into the order FIFO, set last = GRANT_IDX and return to IDLE.
  - The grant is locked until the handshake completes; a late-arriving higher-priority request has no effect.
- Requesters hold AVALID until the handshake, per AXI. Dropping AVALID while in ISSUE is a protocol violation; the arbiter stays in ISSUE and keeps presenting the grant.
- Read routing:
  - head = FIFO head entry.
  - REQ_RVALID[head.idx] = SLAVE_RVALID & ~empty.
  - REQ_RID = head.id.
  - SLAVE_RREADY = ~empty & REQ_RREADY[head.idx].
- FIFO pop happens on SLAVE_RVALID & SLAVE_RREADY & SLAVE_RLAST. Non-last beats do not pop.
- Simultaneous push and pop in one cycle: OUTSTANDING is unchanged, and the FIFO handles pointer wrap and the full-to-empty boundary correctly.
- Empty FIFO with SLAVE_RVALID: SLAVE_RREADY = 0, all REQ_RVALID = 0, PROT_ERR sets and stays set until reset.
- Full FIFO: IDLE issues no grant. At most one grant is ever in flight, so ISSUE always has room for its push.
- Reset, async assert at any time including mid-burst:
  - state = IDLE, last = NUM_REQ-1 (so requester 0 wins first), GRANT_IDX = 0.
  - FIFO empty, OUTSTANDING = 0, PROT_ERR = 0.
  - All outputs 0; SLAVE_AID is constant 0.

## Timing
- Grant latency: one cycle. A request seen in IDLE at edge n gives SLAVE_AVALID high after edge n.
- Peak address throughput: one transaction per 2 cycles (IDLE cycle, then ISSUE handshake).
- OUTSTANDING increments the cycle after the address handshake and decrements the cycle after the RLAST beat handshake.
- Response path is purely combinational, FIFO head to REQ_RVALID/REQ_RID/SLAVE_RREADY, with zero added latency.
- A newly pushed entry is visible at the head the cycle after the push.
- GRANT_IDX and SLAVE_AVALID are registered outputs.
- REQ_AREADY and SLAVE_RREADY are combinational from registered state plus one input each.

## Test plan
- Round robin: NUM_REQ=4, all AVALID held, SLAVE_AREADY=1, read data never returned -> grants 0,1,2,3,0,1,2,3 at one per 2 cycles; grants stop after 8 pushes with OUTSTANDING=8.
- Grant lock: req2 granted, SLAVE_AREADY=0 for 5 cycles, req0 raises AVALID -> GRANT_IDX stays 2 and only REQ_AREADY[2] pulses; next grant goes to 0.
- ID restore: req1 with AID=5 then req3 with AID=2 (ID_WIDTH=3), 4-beat bursts -> REQ_RVALID[1] for 4 beats with RID=5, then REQ_RVALID[3] with RID=2; SLAVE_AID is 0 throughout.
- Backpressure: REQ_RREADY[head]=0 for 3 cycles mid-burst -> SLAVE_RREADY=0 for those cycles, no pop, no lost beat.
- Full plus simultaneous: FIFO full, RLAST handshake and a pending request in the same cycle -> occupancy goes 8 to 7, next cycle grant to ISSUE, handshake returns occupancy to 8; wrap order is preserved.
- Error and reset: SLAVE_RVALID with FIFO empty -> PROT_ERR=1, SLAVE_RREADY=0; ARESETN low mid-burst -> all outputs 0, OUTSTANDING=0 and PROT_ERR=0 asynchronously.
